// File: rtl/seg_pkg.sv
// Active-high seven-segment glyphs, bit order {a,b,c,d,e,f,g} with a as the MSB.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_DARK = 7'b000_0000;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b111_1110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b011_0000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b110_1101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b111_1001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b011_0011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b101_1011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b101_1111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b111_0000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b111_1111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b111_1011;
    localparam logic [SEG_W-1:0] SEG_A = 7'b111_0111;
    localparam logic [SEG_W-1:0] SEG_B = 7'b001_1111;
    localparam logic [SEG_W-1:0] SEG_C = 7'b100_1110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b011_1101;
    localparam logic [SEG_W-1:0] SEG_E = 7'b100_1111;
    localparam logic [SEG_W-1:0] SEG_F = 7'b100_0111;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder; letters only appear when hex_mode is set.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             hex_mode,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_DARK;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = hex_mode ? SEG_A : SEG_DARK;
            4'hB:    seg = hex_mode ? SEG_B : SEG_DARK;
            4'hC:    seg = hex_mode ? SEG_C : SEG_DARK;
            4'hD:    seg = hex_mode ? SEG_D : SEG_DARK;
            4'hE:    seg = hex_mode ? SEG_E : SEG_DARK;
            4'hF:    seg = hex_mode ? SEG_F : SEG_DARK;
            default: seg = SEG_DARK;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed seven-segment scanner with shadowed display data, a dark guard
// interval at the start of each digit slot and output-stage polarity control.
module seven_seg_mux_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int GUARD          = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  hex_mode,
    input  logic                  lz_suppress,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  slot_tick
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_GUARD = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [DIV_W-1:0]      div;
    logic [IDX_W-1:0]      idx;
    logic                  tick;

    logic [4*N_DIGITS-1:0] sh_digits;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_blank;
    logic                  sh_hex;
    logic                  sh_lz;

    logic [3:0]            cur_nibble;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  zero_run;
    logic                  digit_dark;
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_W-1:0]      seg_next;
    logic                  dp_next;
    logic [N_DIGITS-1:0]   an_next;

    assign tick      = (div == DIV_LAST);
    assign slot_tick = tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (tick) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Display logic reads only these copies, so a load can never tear a glyph.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_hex    <= 1'b0;
            sh_lz     <= 1'b0;
        end else if (load) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_blank  <= blank_in;
            sh_hex    <= hex_mode;
            sh_lz     <= lz_suppress;
        end
    end

    // lead_zero[i] is set when every nibble from the leftmost down to i is zero.
    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (sh_digits[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_run;
        end
        lead_zero[0] = 1'b0;
    end

    assign cur_nibble = sh_digits[{idx, 2'b00} +: 4];
    assign digit_dark = sh_blank[idx] | (sh_lz & lead_zero[idx]);

    seg_hex_decode u_decode (
        .nibble   (cur_nibble),
        .hex_mode (sh_hex),
        .seg      (dec_seg)
    );

    always_comb begin
        seg_next     = digit_dark ? SEG_DARK : dec_seg;
        dp_next      = sh_dp[idx] & ~sh_blank[idx];
        an_next      = '0;
        if (div >= DIV_GUARD) begin
            an_next[idx] = 1'b1;
        end
    end

    // Polarity inversion lives only here; everything upstream is active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o <= {SEG_W{SEG_INV}};
            dp_o  <= SEG_INV;
            an_o  <= {N_DIGITS{AN_INV}};
        end else begin
            seg_o <= seg_next ^ {SEG_W{SEG_INV}};
            dp_o  <= dp_next ^ SEG_INV;
            an_o  <= an_next ^ {N_DIGITS{AN_INV}};
        end
    end

endmodule
